// File: rtl/sa_input_skew_feeder.sv
// rtl/sa_input_skew_feeder.sv - reads activation words from SRAM and feeds them diagonally skewed into the systolic array rows
module sa_input_skew_feeder #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LEN_W-1:0]         len,
    input  logic                     halt,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [ROWS*DATA_W-1:0]   mem_rdata,
    output logic                     sa_valid,
    output logic [ROWS*DATA_W-1:0]   sa_data,
    output logic                     sa_last
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FEED  = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       base_r;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        cnt;
    logic                    last_rd;

    logic                    rd_pend, rd_pend_last;
    logic [ROWS*DATA_W-1:0]  stage_data;
    logic                    stage_v, stage_last;

    logic [ROWS*DATA_W-1:0]  src_data;
    logic                    src_v, src_last;
    logic [ROWS-1:0]         word_v;
    logic [ROWS-1:0]         last_v;

    assign last_rd  = (cnt == len_r - LEN_W'(1));
    assign mem_addr = base_r + ADDR_W'(cnt);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign sa_valid = |word_v;
    assign sa_last  = last_v[ROWS-1];

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? DONE : FEED;
            FEED: begin
                if (!halt) begin
                    mem_rd_en = 1'b1;
                    if (last_rd) state_nxt = DRAIN;
                end
            end
            DRAIN: if (!halt && sa_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_r <= '0;
            len_r  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                base_r <= base_addr;
                len_r  <= len;
                cnt    <= '0;
            end else if (mem_rd_en) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

    // Read data arriving during a halt is parked here until the next advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            stage_data   <= '0;
            stage_v      <= 1'b0;
            stage_last   <= 1'b0;
        end else begin
            rd_pend      <= mem_rd_en;
            rd_pend_last <= mem_rd_en && last_rd;
            if (rd_pend && halt) begin
                stage_data <= mem_rdata;
                stage_v    <= 1'b1;
                stage_last <= rd_pend_last;
            end else if (!halt) begin
                stage_v <= 1'b0;
            end
        end
    end

    always_comb begin
        src_v    = stage_v | rd_pend;
        src_last = stage_v ? stage_last : rd_pend_last;
        src_data = '0;
        if (stage_v)
            src_data = stage_data;
        else if (rd_pend)
            src_data = mem_rdata;
    end

    // word_v[k]/last_v[k] flag that lane k currently shows a real word / the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_v <= '0;
            last_v <= '0;
        end else if (!halt) begin
            word_v <= {word_v[ROWS-2:0], src_v};
            last_v <= {last_v[ROWS-2:0], src_v && src_last};
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W-1:0] pipe [0:r];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) pipe[k] <= '0;
            end else if (!halt) begin
                pipe[0] <= src_data[r*DATA_W +: DATA_W];
                for (int k = 1; k <= r; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign sa_data[r*DATA_W +: DATA_W] = pipe[r];
    end

endmodule

// File: tb/tb_sa_input_skew_feeder.sv
// tb/tb_sa_input_skew_feeder.sv - randomized self-checking bench for sa_input_skew_feeder
module tb_sa_input_skew_feeder;

    localparam int ROWS   = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int W      = ROWS * DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy, done, mem_rd_en, sa_valid, sa_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_rdata = '0;
    logic [W-1:0]      sa_data;

    logic [W-1:0]      mem [0:DEPTH-1];
    int                errors = 0;
    int                checks = 0;

    sa_input_skew_feeder #(
        .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .halt(halt), .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sa_valid(sa_valid), .sa_data(sa_data), .sa_last(sa_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A job runs from the cycle start is seen (cycle 0) to the done cycle. Model: reads take the
    // non-halted cycles from cycle 1 on; word j is shown on lane r once j+2+r non-halted cycles
    // have elapsed since cycle 1, and stays until the next non-halted cycle.
    task automatic run_job(input int b, input int l, input int hmode);
        int          adv, rd_cnt, c, j;
        bit          finished, done_next, h, exp_rd, exp_valid, exp_last;
        logic [W-1:0] exp_data, w;
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(b); len = LEN_W'(l); halt = 1'b0;
        adv = 0; rd_cnt = 0; finished = 0; done_next = (l == 0); c = 1;
        while (!finished && c < 20000) begin
            @(posedge clk); #1;
            start     = 1'($urandom_range(0, 1));
            base_addr = ADDR_W'($urandom);
            len       = LEN_W'($urandom);
            h = (hmode == 1) ? ($urandom_range(0, 3) == 0) : (hmode == 2) ? (c == 4 || c == 5) : 1'b0;
            halt = h;
            exp_rd = (rd_cnt < l) && !h;
            exp_data = '0; exp_valid = 0;
            for (int r = 0; r < ROWS; r++) begin
                j = adv - 2 - r;
                if (j >= 0 && j < l) begin
                    w = mem[(b + j) % DEPTH];
                    exp_data[r*DATA_W +: DATA_W] = w[r*DATA_W +: DATA_W];
                    exp_valid = 1;
                end
            end
            exp_last = (l != 0) && (adv - 1 - ROWS == l - 1);
            @(negedge clk);
            check("busy", W'(busy), W'(1'b1));
            check("done", W'(done), W'(done_next));
            check("mem_rd_en", W'(mem_rd_en), W'(exp_rd));
            if (exp_rd) check("mem_addr", W'(mem_addr), W'((b + rd_cnt) % DEPTH));
            check("sa_valid", W'(sa_valid), W'(exp_valid));
            check("sa_last", W'(sa_last), W'(exp_last));
            check("sa_data", sa_data, exp_data);
            if (exp_rd) rd_cnt++;
            if (done_next) finished = 1;
            done_next = exp_last && !h;
            if (!h) adv++;
            c++;
        end
        if (!finished) check("job_timeout", W'(0), W'(1));
        @(posedge clk); #1;
        start = 1'b0; halt = 1'b0;
        @(negedge clk);
        check("idle_busy", W'(busy), W'(1'b0));
        check("idle_done", W'(done), W'(1'b0));
        check("idle_valid", W'(sa_valid), W'(1'b0));
        check("idle_rd", W'(mem_rd_en), W'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_done"}, W'(done), W'(0));
        check({tag, "_rd"}, W'(mem_rd_en), W'(0));
        check({tag, "_addr"}, W'(mem_addr), W'(0));
        check({tag, "_valid"}, W'(sa_valid), W'(0));
        check({tag, "_last"}, W'(sa_last), W'(0));
        check({tag, "_data"}, sa_data, W'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
        mem[5] = 32'h44332211;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        run_job(5, 1, 0);
        run_job(int'($urandom_range(0, DEPTH - 1)), 3, 0);
        run_job(int'($urandom_range(0, DEPTH - 1)), 3, 2);
        run_job(int'($urandom_range(0, DEPTH - 1)), 0, 0);
        run_job(DEPTH - 1, 2, 0);
        run_job(int'($urandom_range(0, DEPTH - 1)), 0, 1);

        // Abort a len=8 job with reset in its fourth cycle.
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'($urandom); len = LEN_W'(8);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("pre_reset_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        run_job(int'($urandom_range(0, DEPTH - 1)), 3, 0);

        for (int n = 0; n < 12; n++)
            run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 1)));
        run_job(int'($urandom_range(0, DEPTH - 1)), (1 << LEN_W) - 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
